process_engine: RTL and testbench

Parametrised, clocked successor to the two-bit combinational process function. It accepts operate-on-accumulator commands through a valid/ready port and buffers them in a small FIFO. Commands execute one per cycle against a WIDTH-bit result register, with saturating or wrapping arithmetic and a sticky overflow flag. An asynchronous pause input is synchronised and both stalls execution and drives the light output `l`, which is the inverse of the synchronised pause.

---
 rtl/process_engine.sv | 136 +++++++++++++
 tb/tb_process_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/process_engine.sv
// Accumulator engine: commands are queued in a small FIFO and executed one
// per cycle against a result register, with a synchronised pause input.
module process_engine #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter bit SAT   = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     n_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_op,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     clr_ovf,
   output logic [WIDTH-1:0]         f,
   output logic                     out_valid,
   output logic                     ovf,
   output logic                     l,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_e;

   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] data;
   } cmd_t;

   state_e            state_q, state_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              l_q, l_d;
   logic [CW-1:0]     count_q, count_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]  f_q, f_d;
   logic              ovf_q, ovf_d;
   logic              out_valid_q, out_valid_d;
   cmd_t              mem_q [DEPTH];

   logic              push, pop, set_ovf;
   cmd_t              head;
   logic [WIDTH:0]    sum, diff;

   assign in_ready  = (count_q != FULL);
   assign f         = f_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;
   assign l         = l_q;
   assign count     = count_q;

   always_comb begin
      push     = in_valid && in_ready;
      pop      = (state_q == RUN);
      head     = mem_q[rd_ptr_q];
      sync1_d  = n_in;
      sync2_d  = sync1_q;
      l_d      = ~sync2_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      sum      = {1'b0, f_q} + {1'b0, head.data};
      diff     = {1'b0, f_q} - {1'b0, head.data};
      f_d      = f_q;
      set_ovf  = 1'b0;
      out_valid_d = pop;
      if (pop) begin
         unique case (head.op)
            OP_LOAD:  f_d = head.data;
            OP_CLEAR: f_d = '0;
            OP_ADD: begin
               set_ovf = sum[WIDTH];
               f_d = (sum[WIDTH] && SAT) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            end
            OP_SUB: begin
               set_ovf = diff[WIDTH];
               f_d = (diff[WIDTH] && SAT) ? '0 : diff[WIDTH-1:0];
            end
            default: f_d = f_q;
         endcase
      end
      ovf_d = set_ovf | (ovf_q & ~clr_ovf);
      // State tracks the synchroniser and occupancy as they will be after this edge
      if (sync1_q)
         state_d = PAUSED;
      else if (count_d != '0)
         state_d = RUN;
      else
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PAUSED;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         l_q         <= 1'b0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         f_q         <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         l_q         <= l_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         f_q         <= f_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= cmd_t'{op: in_op, data: in_data};
      end
   end

endmodule

// File: tb/tb_process_engine.sv
// Directed bench for process_engine: a saturating and a wrapping instance
// share one stimulus stream.
module tb_process_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       n_in, in_valid, clr_ovf;
   logic [1:0] in_op, in_data;
   logic       rdy_a, ov_a, ovf_a, l_a;
   logic       rdy_b, ov_b, ovf_b, l_b;
   logic [1:0] f_a, f_b;
   logic [2:0] cnt_a, cnt_b;
   int         n_cmp = 0;
   int         n_err = 0;

   localparam logic [1:0] LD = 2'b00;
   localparam logic [1:0] AD = 2'b01;
   localparam logic [1:0] SB = 2'b10;
   localparam logic [1:0] CL = 2'b11;

   process_engine #(.WIDTH(2), .DEPTH(4), .SAT(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .n_in(n_in), .in_valid(in_valid),
      .in_ready(rdy_a), .in_op(in_op), .in_data(in_data),
      .clr_ovf(clr_ovf), .f(f_a), .out_valid(ov_a), .ovf(ovf_a),
      .l(l_a), .count(cnt_a));

   process_engine #(.WIDTH(2), .DEPTH(4), .SAT(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .n_in(n_in), .in_valid(in_valid),
      .in_ready(rdy_b), .in_op(in_op), .in_data(in_data),
      .clr_ovf(clr_ovf), .f(f_b), .out_valid(ov_b), .ovf(ovf_b),
      .l(l_b), .count(cnt_b));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [1:0] op, input logic [1:0] d);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      step();
   endtask

   initial begin
      n_in = 1'b0; clr_ovf = 1'b0;
      in_valid = 1'b1; in_op = AD; in_data = 2'd1;
      #1 rst_n = 1'b0;
      step(); step();
      chk("rst_f", f_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_ov", ov_a, 0);
      chk("rst_l", l_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_rdy", rdy_a, 1);

      in_valid = 1'b0;
      rst_n = 1'b1;
      step(); chk("l_e1", l_a, 0);
      step(); chk("l_e2", l_a, 0);
      step(); chk("l_e3", l_a, 1);

      // back-to-back LOAD 1, ADD 2, ADD 1
      cmd(LD, 2'd1);
      chk("ar_cnt0", cnt_a, 1);
      chk("ar_ov0", ov_a, 0);
      cmd(AD, 2'd2);
      chk("ar_f1", f_a, 1);
      chk("ar_ov1", ov_a, 1);
      chk("ar_cnt1", cnt_a, 1);
      cmd(AD, 2'd1);
      chk("ar_f2", f_a, 3);
      chk("ar_ov2", ov_a, 1);
      chk("ar_ovf2", ovf_a, 0);
      in_valid = 1'b0;
      step();
      chk("ar_f3", f_a, 3);
      chk("ar_f3w", f_b, 0);
      chk("ar_ov3", ov_a, 1);
      chk("ar_ovf3", ovf_a, 1);
      chk("ar_ovf3w", ovf_b, 1);
      step();
      chk("ar_ov4", ov_a, 0);
      chk("ar_cnt4", cnt_a, 0);

      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      chk("clr1", ovf_a, 0);

      // underflow
      cmd(LD, 2'd1);
      cmd(SB, 2'd3);
      in_valid = 1'b0;
      step();
      chk("uf_f", f_a, 0);
      chk("uf_fw", f_b, 2);
      chk("uf_ovf", ovf_a, 1);
      chk("uf_ovfw", ovf_b, 1);
      cmd(CL, 2'd3);
      in_valid = 1'b0;
      step();
      chk("cl_f", f_a, 0);
      chk("cl_fw", f_b, 0);
      chk("cl_ovf", ovf_a, 1);
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      chk("clr2", ovf_b, 0);

      // pause and backpressure
      n_in = 1'b1;
      step(); step(); step();
      chk("p_l", l_a, 0);
      cmd(LD, 2'd2);
      cmd(AD, 2'd1);
      cmd(SB, 2'd1);
      cmd(AD, 2'd3);
      chk("p_rdy", rdy_a, 0);
      chk("p_cnt", cnt_a, 4);
      cmd(LD, 2'd0);
      chk("p_cnt5", cnt_a, 4);
      chk("p_f", f_a, 0);
      chk("p_ov", ov_a, 0);
      in_valid = 1'b0;
      n_in = 1'b0;
      step();
      chk("r_ov1", ov_a, 0);
      step();
      chk("r_ov2", ov_a, 0);
      chk("r_cnt2", cnt_a, 4);
      step();
      chk("r_ov3", ov_a, 1);
      chk("r_f3", f_a, 2);
      chk("r_l3", l_a, 1);
      step();
      chk("r_f4", f_a, 3);
      chk("r_ov4", ov_a, 1);
      step();
      chk("r_f5", f_a, 2);
      step();
      chk("r_f6", f_a, 3);
      chk("r_f6w", f_b, 1);
      chk("r_ovf6", ovf_a, 1);
      chk("r_ov6", ov_a, 1);
      step();
      chk("r_ov7", ov_a, 0);
      chk("r_cnt7", cnt_a, 0);
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      chk("clr3", ovf_a, 0);

      // pause mid-drain, then set/clear race on the overflow flag
      n_in = 1'b1;
      step(); step(); step();
      cmd(CL, 2'd0);
      cmd(AD, 2'd1);
      cmd(AD, 2'd1);
      cmd(AD, 2'd3);
      in_valid = 1'b0;
      n_in = 1'b0;
      step(); step(); step();
      chk("md_f0", f_a, 0);
      chk("md_cnt0", cnt_a, 3);
      n_in = 1'b1;
      step();
      chk("md_f1", f_a, 1);
      step();
      chk("md_f2", f_a, 2);
      chk("md_cnt2", cnt_a, 1);
      step();
      chk("md_ov3", ov_a, 0);
      chk("md_cnt3", cnt_a, 1);
      step();
      chk("md_cnt4", cnt_a, 1);
      chk("md_f4", f_a, 2);
      n_in = 1'b0;
      step(); step();
      clr_ovf = 1'b1;
      step();
      chk("race_f", f_a, 3);
      chk("race_fw", f_b, 1);
      chk("race_ovf", ovf_a, 1);
      chk("race_ovfw", ovf_b, 1);
      step();
      clr_ovf = 1'b0;
      chk("race_clr", ovf_a, 0);

      // reset mid-drain
      n_in = 1'b1;
      step(); step(); step();
      cmd(LD, 2'd1);
      cmd(LD, 2'd2);
      cmd(LD, 2'd3);
      cmd(LD, 2'd1);
      in_valid = 1'b0;
      n_in = 1'b0;
      step(); step(); step();
      chk("rd_cnt", cnt_a, 3);
      chk("rd_f", f_a, 1);
      rst_n = 1'b0;
      #1;
      chk("rd_cnt0", cnt_a, 0);
      chk("rd_f0", f_a, 0);
      chk("rd_ov0", ov_a, 0);
      chk("rd_l0", l_a, 0);
      chk("rd_rdy0", rdy_a, 1);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rd_noov", ov_a, 0);
         chk("rd_nocnt", cnt_a, 0);
      end
      cmd(LD, 2'd2);
      in_valid = 1'b0;
      chk("rd_push", cnt_a, 1);
      step();
      chk("rd_ex_ov", ov_a, 1);
      chk("rd_ex_f", f_a, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
